// File: rtl/alu_seq.sv
// Registered ALU with persistent PSR flags, single-cycle logic/arithmetic ops and
// iterative shift / shift-add multiply driven by a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | accepts start; single-cycle ops complete here
// S_RUN  | iterative shift or multiply in progress (busy_o=1)
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] rsrc_i,
    input  logic [WIDTH-1:0] rdest_i,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       flags_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_LSH  = 4'd7;
    localparam logic [3:0] OP_RSH  = 4'd8;
    localparam logic [3:0] OP_ARSH = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_ADDC = 4'd11;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH:0]     sum;
    logic               ovf, lt_u, eq, lt_s;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   acc_next;

    // One adder serves ADD, SUB (rdest + ~rsrc + 1) and ADDC (carry-in from C).
    always_comb begin
        add_b   = (opcode_i == OP_SUB) ? ~rsrc_i : rsrc_i;
        add_cin = 1'b0;
        if (opcode_i == OP_SUB) begin
            add_cin = 1'b1;
        end else if (opcode_i == OP_ADDC) begin
            add_cin = flags_q[0];
        end
        sum   = {1'b0, rdest_i} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        ovf   = (rdest_i[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != rdest_i[WIDTH-1]);
        lt_u  = rdest_i < rsrc_i;
        eq    = rdest_i == rsrc_i;
        lt_s  = $signed(rdest_i) < $signed(rsrc_i);
        shamt = rsrc_i[SHAMT_W-1:0];
    end

    always_comb begin
        shifted = work_q;
        case (op_q)
            OP_LSH:  shifted = {work_q[WIDTH-2:0], 1'b0};
            OP_RSH:  shifted = {1'b0, work_q[WIDTH-1:1]};
            OP_ARSH: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shifted = work_q;
        endcase
        acc_next = acc_q + (mplier_q[0] ? work_q : '0);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d = opcode_i;
                    case (opcode_i)
                        OP_ADD, OP_SUB, OP_ADDC: begin
                            result_d = sum[WIDTH-1:0];
                            flags_d  = {lt_s, eq, ovf, lt_u, sum[WIDTH]};
                            done_d   = 1'b1;
                        end
                        OP_CMP: begin
                            flags_d[1] = lt_u;
                            flags_d[3] = eq;
                            flags_d[4] = lt_s;
                            done_d     = 1'b1;
                        end
                        OP_AND: begin
                            result_d = rdest_i & rsrc_i;
                            done_d   = 1'b1;
                        end
                        OP_OR: begin
                            result_d = rdest_i | rsrc_i;
                            done_d   = 1'b1;
                        end
                        OP_XOR: begin
                            result_d = rdest_i ^ rsrc_i;
                            done_d   = 1'b1;
                        end
                        OP_NOT: begin
                            result_d = ~rdest_i;
                            done_d   = 1'b1;
                        end
                        OP_LSH, OP_RSH, OP_ARSH: begin
                            work_d = rdest_i;
                            cnt_d  = {1'b0, shamt};
                            if (shamt == '0) begin
                                result_d = rdest_i;
                                done_d   = 1'b1;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        OP_MUL: begin
                            work_d   = rdest_i;
                            mplier_d = rsrc_i;
                            acc_d    = '0;
                            cnt_d    = CNT_MUL;
                            state_d  = S_RUN;
                        end
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    acc_d    = acc_next;
                    work_d   = {work_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end else begin
                    work_d = shifted;
                end
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    result_d = (op_q == OP_MUL) ? acc_next : shifted;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result_o = result_q;
    assign flags_o  = flags_q;
    assign busy_o   = (state_q == S_RUN);
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: transaction-level reference model checked every
// cycle, directed literal cases, then randomized traffic with dropped mid-op starts.
module tb_alu_seq;
    localparam int W = 16;

    logic          clk_i     = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          start_i   = 1'b0;
    logic [3:0]    opcode_i  = '0;
    logic [W-1:0]  rsrc_i    = '0;
    logic [W-1:0]  rdest_i   = '0;
    logic [W-1:0]  result_o;
    logic [4:0]    flags_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .start_i   (start_i),
        .opcode_i  (opcode_i),
        .rsrc_i    (rsrc_i),
        .rdest_i   (rdest_i),
        .result_o  (result_o),
        .flags_o   (flags_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation reference: final result, flags, err and latency in edges.
    function automatic void model_op(input logic [3:0] op, input logic [15:0] d, input logic [15:0] s,
                                     input logic [15:0] rin, input logic [4:0] fin,
                                     output logic [15:0] res, output logic [4:0] fl,
                                     output bit er, output int lat);
        int  sd, ss, t, sg, sh;
        bit  c, l, z, n, f;
        sd  = int'($signed(d));
        ss  = int'($signed(s));
        sh  = int'(s[3:0]);
        l   = d < s;
        z   = d == s;
        n   = sd < ss;
        res = rin;
        fl  = fin;
        er  = 1'b0;
        lat = 1;
        case (op)
            4'd0, 4'd1, 4'd11: begin
                if (op == 4'd0) begin
                    t  = int'(d) + int'(s);
                    sg = sd + ss;
                end else if (op == 4'd1) begin
                    t  = int'(d) - int'(s) + 65536;
                    sg = sd - ss;
                end else begin
                    t  = int'(d) + int'(s) + int'(fin[0]);
                    sg = sd + ss + int'(fin[0]);
                end
                res = t[15:0];
                c   = t[16];
                f   = (sg > 32767) || (sg < -32768);
                fl  = {n, z, f, l, c};
            end
            4'd2:  fl  = {n, z, fin[2], l, fin[0]};
            4'd3:  res = d & s;
            4'd4:  res = d | s;
            4'd5:  res = d ^ s;
            4'd6:  res = ~d;
            4'd7:  begin res = 16'(int'(d) << sh); lat = 1 + sh; end
            4'd8:  begin res = 16'(int'(d) >> sh); lat = 1 + sh; end
            4'd9:  begin res = 16'(sd >>> sh);     lat = 1 + sh; end
            4'd10: begin res = 16'(longint'(d) * longint'(s)); lat = 1 + W; end
            default: er = 1'b1;
        endcase
    endfunction

    logic [15:0] m_res = '0, p_res;
    logic [4:0]  m_flags = '0, p_flags;
    bit          m_busy = 0, m_done = 0, m_err = 0, p_err;
    int          m_rem = 0, p_lat;
    bit          checking = 0;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_res = '0; m_flags = '0; m_busy = 0; m_done = 0; m_err = 0; m_rem = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_res  = p_res;
                end
            end else if (start_i) begin
                model_op(opcode_i, rdest_i, rsrc_i, m_res, m_flags, p_res, p_flags, p_err, p_lat);
                if (p_lat == 1) begin
                    m_res   = p_res;
                    m_flags = p_flags;
                    m_done  = 1;
                    m_err   = p_err;
                end else begin
                    m_rem  = p_lat - 1;
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (checking && reset_n_i) begin
            check("cyc_result", result_o, m_res);
            check("cyc_flags", flags_o, m_flags);
            check("cyc_busy", busy_o, m_busy);
            check("cyc_done", done_o, m_done);
            if (m_done) check("cyc_err", err_o, m_err);
        end
    end

    // Entered and left at a negedge; pulse_at injects an ADD start at that loop index.
    task automatic do_op(input logic [3:0] op, input logic [15:0] d, input logic [15:0] s,
                         input bit noise, input int pulse_at, output int lat, output int nbusy);
        opcode_i = op; rdest_i = d; rsrc_i = s; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done_o && lat < W + 4) begin
            if (busy_o) nbusy++;
            if (lat == pulse_at) begin
                start_i = 1'b1; opcode_i = 4'd0; rdest_i = 16'h1111; rsrc_i = 16'h2222;
            end else if (noise && busy_o && $urandom_range(0, 2) == 0) begin
                start_i = 1'b1; opcode_i = 4'($urandom_range(0, 15));
                rdest_i = 16'($urandom); rsrc_i = 16'($urandom);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            lat++;
        end
        start_i = 1'b0;
        if (!done_o) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_op(input string name, input logic [15:0] res, input logic [4:0] fl,
                             input int lat, input int lat_exp);
        check({name, "_result"}, result_o, res);
        check({name, "_flags"}, flags_o, fl);
        check({name, "_model_result"}, m_res, res);
        check({name, "_model_flags"}, m_flags, fl);
        check({name, "_latency"}, lat, lat_exp);
        check({name, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, nb, dn;
        repeat (2) @(negedge clk_i);
        check("rst_result", result_o, 0);
        check("rst_flags", flags_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        #2 reset_n_i = 1'b1;
        @(negedge clk_i);
        checking = 1;

        do_op(4'd0, 16'h7FFF, 16'h0001, 0, -1, lat, nb);
        expect_op("add_ovf", 16'h8000, 5'b00100, lat, 1);
        check("add_ovf_busy", nb, 0);
        do_op(4'd1, 16'h0005, 16'h0005, 0, -1, lat, nb);
        expect_op("sub_eq", 16'h0000, 5'b01001, lat, 1);
        do_op(4'd2, 16'hFFFF, 16'h0001, 0, -1, lat, nb);
        expect_op("cmp", 16'h0000, 5'b10001, lat, 1);
        do_op(4'd9, 16'h8000, 16'h0004, 0, -1, lat, nb);
        expect_op("arsh", 16'hF800, 5'b10001, lat, 5);
        check("arsh_busy", nb, 4);
        do_op(4'd8, 16'h8000, 16'h0004, 0, -1, lat, nb);
        expect_op("rsh", 16'h0800, 5'b10001, lat, 5);
        do_op(4'd7, 16'h0001, 16'h000F, 0, -1, lat, nb);
        expect_op("lsh15", 16'h8000, 5'b10001, lat, 16);
        do_op(4'd9, 16'hABCD, 16'h0000, 0, -1, lat, nb);
        expect_op("shift0", 16'hABCD, 5'b10001, lat, 1);
        do_op(4'd10, 16'h0123, 16'h0010, 0, 6, lat, nb);
        expect_op("mul", 16'h1230, 5'b10001, lat, 17);
        check("mul_busy", nb, 16);
        dn = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o) dn++;
        end
        check("mul_no_extra_done", dn, 0);
        check("mul_held", result_o, 16'h1230);

        opcode_i = 4'd10; rdest_i = 16'h00FF; rsrc_i = 16'h00FF; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (6) @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        check("midrst_result", result_o, 0);
        check("midrst_flags", flags_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        repeat (2) @(negedge clk_i);
        #2 reset_n_i = 1'b1;
        @(negedge clk_i);
        do_op(4'd0, 16'h0002, 16'h0003, 0, -1, lat, nb);
        expect_op("add_after_rst", 16'h0005, 5'b10010, lat, 1);

        do_op(4'd0, 16'hFFFF, 16'h0001, 0, -1, lat, nb);
        expect_op("add_carry", 16'h0000, 5'b10001, lat, 1);
        do_op(4'd11, 16'h0001, 16'h0001, 0, -1, lat, nb);
        expect_op("addc", 16'h0003, 5'b01000, lat, 1);
        do_op(4'd15, 16'h1234, 16'h5678, 0, -1, lat, nb);
        check("illegal_done", done_o, 1);
        check("illegal_err", err_o, 1);
        check("illegal_result", result_o, 16'h0003);
        check("illegal_flags", flags_o, 5'b01000);

        for (int i = 0; i < 400; i++) begin
            do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1, -1, lat, nb);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
        repeat (3) @(negedge clk_i);
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
